ifetch_queue: RTL and testbench

- Sits between the instruction fetch unit and decode.
- Each cycle that the fetch unit's PC is accepted, issues a fixed-latency (1-cycle) read to instruction memory and tags the response with PC, PC+4 and fault flags.
- Buffers responses in a small FIFO and presents them to decode over a valid/ready handshake.
- Back-pressures the fetch unit via o_stall; squashes wrong-path entries on redirect.

---
 rtl/ifetch_queue.sv | 145 ++++++++++++++
 tb/tb_ifetch_queue.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch-to-decode instruction queue.
// Accepts one PC per cycle from the fetch unit, issues a 1-cycle-latency
// instruction memory read, tags the response with PC/PC+4/fault flags and
// buffers it in a DEPTH-entry FIFO presented to decode via valid/ready.
// Faulted fetches skip the memory read and deliver NOP_INST instead.
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to
// decode when the FIFO is empty (1-cycle PC-to-decode latency).
module ifetch_queue #(
    parameter int          XLEN     = 32,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_4,
    input  logic            i_fault_misaligned,
    input  logic            i_fault_access,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_4,
    output logic            o_fault_misaligned,
    output logic            o_fault_access
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // FIFO storage (data only, never reset)
    logic [31:0]     r_fifo_inst [DEPTH];
    logic [XLEN-1:0] r_fifo_pc   [DEPTH];
    logic [XLEN-1:0] r_fifo_pc_4 [DEPTH];
    logic            r_fifo_fm   [DEPTH];
    logic            r_fifo_fa   [DEPTH];

    // FIFO control
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // In-flight slot: the fetch issued last cycle whose response arrives now
    logic            r_vld_p1;
    logic [XLEN-1:0] r_pc_p1;
    logic [XLEN-1:0] r_pc_4_p1;
    logic            r_fm_p1;
    logic            r_fa_p1;
    logic            r_flt_p1;

    logic            w_live;
    logic            w_empty;
    logic            w_byp;
    logic            w_pop;
    logic            w_pop_fifo;
    logic            w_push;
    logic            w_issue_ok;
    logic            w_issue;
    logic [CW:0]     w_occ;
    logic [31:0]     w_rsp_inst;

    // Stage p0 -> p1: fetch acceptance and memory request
    assign w_live      = !i_rst && !i_flush;
    assign w_empty     = (r_count == '0);
    assign w_rsp_inst  = r_flt_p1 ? NOP_INST : i_imem_rdata;

`ifdef IFQ_BYPASS_EN
    assign w_byp       = w_empty && r_vld_p1;
`else
    assign w_byp       = 1'b0;
`endif

    assign o_valid     = w_live && (!w_empty || w_byp);
    assign w_pop       = o_valid && i_ready;
    assign w_pop_fifo  = w_pop && !w_empty;
    // A bypassed response that decode takes this cycle never enters the FIFO
    assign w_push      = w_live && r_vld_p1 && !(w_byp && i_ready);

    // Occupancy after this cycle settles; cannot underflow since a pop
    // implies either a stored entry or a bypassed in-flight response.
    assign w_occ       = {1'b0, r_count} + (CW+1)'(r_vld_p1) - (CW+1)'(w_pop);
    assign w_issue_ok  = (w_occ < (CW+1)'(DEPTH));
    assign w_issue     = w_live && w_issue_ok;

    assign o_stall     = w_live && !w_issue_ok;
    assign o_imem_req  = w_issue && !i_fault_misaligned && !i_fault_access;
    assign o_imem_addr = i_pc;

    // Head-of-queue selection (FIFO head, or in-flight response when bypassing)
    always_comb begin
        o_inst             = r_fifo_inst[r_rd_ptr];
        o_pc               = r_fifo_pc[r_rd_ptr];
        o_pc_4             = r_fifo_pc_4[r_rd_ptr];
        o_fault_misaligned = r_fifo_fm[r_rd_ptr];
        o_fault_access     = r_fifo_fa[r_rd_ptr];
        if (w_byp) begin
            o_inst             = w_rsp_inst;
            o_pc               = r_pc_p1;
            o_pc_4             = r_pc_4_p1;
            o_fault_misaligned = r_fm_p1;
            o_fault_access     = r_fa_p1;
        end
    end

    // Stage p1 -> FIFO: control state; flush and reset both empty the queue
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_fifo)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop_fifo);
            r_vld_p1 <= w_issue;
        end
    end

    // Data capture: in-flight slot on issue, FIFO entry on push
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_pc_p1   <= i_pc;
            r_pc_4_p1 <= i_pc_4;
            r_fm_p1   <= i_fault_misaligned;
            r_fa_p1   <= i_fault_access;
            r_flt_p1  <= i_fault_misaligned || i_fault_access;
        end
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= w_rsp_inst;
            r_fifo_pc[r_wr_ptr]   <= r_pc_p1;
            r_fifo_pc_4[r_wr_ptr] <= r_pc_4_p1;
            r_fifo_fm[r_wr_ptr]   <= r_fm_p1;
            r_fifo_fa[r_wr_ptr]   <= r_fa_p1;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a queue-based reference model of the
// fetch queue plus a simple fetch unit and instruction memory.
module tb_ifetch_queue;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            i_clk, i_rst, i_flush, i_ready;
    logic [XLEN-1:0] i_pc, i_pc_4;
    logic            i_fault_misaligned, i_fault_access;
    logic            o_stall, o_imem_req, o_valid;
    logic [XLEN-1:0] o_imem_addr, o_pc, o_pc_4;
    logic [31:0]     i_imem_rdata, o_inst;
    logic            o_fault_misaligned, o_fault_access;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_4(i_pc_4),
        .i_fault_misaligned(i_fault_misaligned), .i_fault_access(i_fault_access),
        .i_flush(i_flush), .o_stall(o_stall), .o_imem_req(o_imem_req),
        .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc),
        .o_pc_4(o_pc_4), .o_fault_misaligned(o_fault_misaligned),
        .o_fault_access(o_fault_access)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fm;
        logic        fa;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_busy;
    ent_t        m_slot;
    bit          m_slot_flt;
    logic [31:0] f_pc;
    bit          cur_rst, cur_flush;

    // Expectations for the current cycle
    bit   e_valid, e_stall, e_req, e_issue, e_byp, e_pop;
    ent_t e_head;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Drive one cycle of inputs and compute what the queue should show.
    task automatic drive(input bit rst, input bit flush, input bit rdy,
                         input bit fm, input bit fa);
        bit live;
        @(negedge i_clk);
        i_rst = rst; i_flush = flush; i_ready = rdy;
        i_fault_misaligned = fm; i_fault_access = fa;
        i_pc = f_pc; i_pc_4 = f_pc + 32'd4;
        i_imem_rdata = (m_busy && !m_slot_flt) ? memf(m_slot.pc) : $urandom;
        cur_rst = rst; cur_flush = flush;
        live = !rst && !flush;
`ifdef IFQ_BYPASS_EN
        e_byp = live && (mq.size() == 0) && m_busy;
`else
        e_byp = 1'b0;
`endif
        e_valid = live && ((mq.size() != 0) || e_byp);
        e_head  = (mq.size() != 0) ? mq[0] : m_slot;
        e_pop   = e_valid && rdy;
        e_stall = live && ((mq.size() + int'(m_busy) - int'(e_pop)) >= DEPTH);
        e_issue = live && !e_stall;
        e_req   = e_issue && !fm && !fa;
        #1;
    endtask

    // Clock edge: move the model forward by the queue rules.
    task automatic advance();
        bit consumed;
        @(posedge i_clk);
        if (cur_rst || cur_flush) begin
            mq.delete();
            m_busy = 1'b0;
        end else begin
            consumed = e_byp && e_pop;
            if (e_pop && !e_byp) void'(mq.pop_front());
            if (m_busy && !consumed) mq.push_back(m_slot);
            m_busy = e_issue;
            if (e_issue) begin
                m_slot_flt = i_fault_misaligned || i_fault_access;
                m_slot = '{inst: m_slot_flt ? NOP : memf(f_pc), pc: f_pc,
                           pc4: f_pc + 32'd4, fm: i_fault_misaligned,
                           fa: i_fault_access};
                f_pc = f_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 1, 0, 0);
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got v/s/r=%b%b%b exp 000",
                         c, o_valid, o_stall, o_imem_req);
            end
            advance();
        end
        f_pc = 32'h0;
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got v=%b s=%b exp v=0 s=0", o_valid, o_stall);
        end
        advance();
    endtask

    task automatic test_stream();
        int first_valid;
        do_reset();
        f_pc = 32'h0;
        first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 1, 0, 0);
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== {e_valid, e_stall, e_req} ||
                o_imem_addr !== f_pc) begin
                n_fail++;
                $display("FAIL stream_ctl cyc=%0d got v/s/r=%b%b%b addr=%h exp %b%b%b addr=%h",
                         c, o_valid, o_stall, o_imem_req, o_imem_addr,
                         e_valid, e_stall, e_req, f_pc);
            end
            if (e_valid) begin
                n_checks++;
                if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head) begin
                    n_fail++;
                    $display("FAIL stream_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             c, o_pc, o_inst, e_head.pc, e_head.inst);
                end
            end
            if (o_valid && first_valid < 0) first_valid = c;
            n_checks++;
            if (o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_no_stall cyc=%0d got stall=%b exp 0", c, o_stall);
            end
            advance();
        end
        n_checks++;
        if (first_valid != LAT) begin
            n_fail++;
            $display("FAIL stream_latency got %0d exp %0d", first_valid, LAT);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        f_pc = 32'h100;
        for (int c = 0; c < 16; c++) begin
            drive(0, 0, (c >= 6), 0, 0);
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== {e_valid, e_stall, e_req}) begin
                n_fail++;
                $display("FAIL bp_ctl cyc=%0d got v/s/r=%b%b%b exp %b%b%b",
                         c, o_valid, o_stall, o_imem_req, e_valid, e_stall, e_req);
            end
            if (e_valid) begin
                n_checks++;
                if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head) begin
                    n_fail++;
                    $display("FAIL bp_data cyc=%0d got pc=%h exp pc=%h", c, o_pc, e_head.pc);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (o_stall !== 1'b1 || i_pc !== 32'h108) begin
                    n_fail++;
                    $display("FAIL bp_third_pc_held got stall=%b pc=%h exp stall=1 pc=00000108",
                             o_stall, i_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_fault();
        int seen;
        do_reset();
        f_pc = 32'h4000_0000;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 1, (c == 1), (c == 0));
            if (c == 0) begin
                n_checks++;
                if (o_imem_req !== 1'b0 || o_stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_no_req got req=%b stall=%b exp req=0 stall=0",
                             o_imem_req, o_stall);
                end
            end
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== {e_valid, e_stall, e_req}) begin
                n_fail++;
                $display("FAIL fault_ctl cyc=%0d got v/s/r=%b%b%b exp %b%b%b",
                         c, o_valid, o_stall, o_imem_req, e_valid, e_stall, e_req);
            end
            if (o_valid && o_pc === 32'h4000_0000) begin
                seen++;
                n_checks++;
                if (o_inst !== NOP || o_fault_access !== 1'b1 || o_fault_misaligned !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_entry got inst=%h fa=%b fm=%b exp inst=%h fa=1 fm=0",
                             o_inst, o_fault_access, o_fault_misaligned, NOP);
                end
            end
            if (e_valid) begin
                n_checks++;
                if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head) begin
                    n_fail++;
                    $display("FAIL fault_data cyc=%0d got pc=%h inst=%h fm=%b exp pc=%h inst=%h fm=%b",
                             c, o_pc, o_inst, o_fault_misaligned, e_head.pc, e_head.inst, e_head.fm);
                end
            end
            advance();
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL fault_delivered_once got %0d exp 1", seen);
        end
    endtask

    task automatic test_flush();
        int first_pc_seen;
        do_reset();
        f_pc = 32'h10;
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0);
            advance();
        end
        drive(0, 1, 1, 0, 0);
        n_checks++;
        if ({o_valid, o_stall, o_imem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_cycle got v/s/r=%b%b%b exp 000", o_valid, o_stall, o_imem_req);
        end
        advance();
        f_pc = 32'h200;
        first_pc_seen = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 0, 0);
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== {e_valid, e_stall, e_req}) begin
                n_fail++;
                $display("FAIL flush_ctl cyc=%0d got v/s/r=%b%b%b exp %b%b%b",
                         c, o_valid, o_stall, o_imem_req, e_valid, e_stall, e_req);
            end
            if (o_valid) begin
                n_checks++;
                if (!first_pc_seen && o_pc !== 32'h200) begin
                    n_fail++;
                    $display("FAIL flush_first_pc got %h exp 00000200", o_pc);
                end else if (o_pc < 32'h200) begin
                    n_fail++;
                    $display("FAIL flush_stale_entry got pc=%h exp >= 00000200", o_pc);
                end
                first_pc_seen = 1;
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        int first_pc_seen;
        do_reset();
        f_pc = 32'h300;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0);
            advance();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 1, 0, 0);
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL midreset_outputs cyc=%0d got v/s/r=%b%b%b exp 000",
                         c, o_valid, o_stall, o_imem_req);
            end
            advance();
        end
        f_pc = 32'h800;
        first_pc_seen = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 0, 0);
            if (o_valid && !first_pc_seen) begin
                first_pc_seen = 1;
                n_checks++;
                if (o_pc !== 32'h800) begin
                    n_fail++;
                    $display("FAIL midreset_first_pc got %h exp 00000800", o_pc);
                end
            end
            if (e_valid) begin
                n_checks++;
                if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head ||
                    o_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_data cyc=%0d got v=%b pc=%h exp v=1 pc=%h",
                             c, o_valid, o_pc, e_head.pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        f_pc = 32'h900;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0);
            advance();
        end
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 1, 0, 0);
            n_checks++;
            if (o_stall !== 1'b0 || o_valid !== 1'b1 ||
                (mq.size() + int'(m_busy)) != DEPTH) begin
                n_fail++;
                $display("FAIL full_pushpop cyc=%0d got stall=%b valid=%b occ=%0d exp stall=0 valid=1 occ=%0d",
                         c, o_stall, o_valid, mq.size() + int'(m_busy), DEPTH);
            end
            n_checks++;
            if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head) begin
                n_fail++;
                $display("FAIL full_pushpop_data cyc=%0d got pc=%h exp pc=%h", c, o_pc, e_head.pc);
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit rst, fl;
        do_reset();
        f_pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            fl  = ($urandom_range(0, 99) < 6);
            drive(rst, fl, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            n_checks++;
            if ({o_valid, o_stall, o_imem_req} !== {e_valid, e_stall, e_req} ||
                o_imem_addr !== f_pc) begin
                n_fail++;
                $display("FAIL rand_ctl cyc=%0d got v/s/r=%b%b%b addr=%h exp %b%b%b addr=%h",
                         c, o_valid, o_stall, o_imem_req, o_imem_addr,
                         e_valid, e_stall, e_req, f_pc);
            end
            if (e_valid) begin
                n_checks++;
                if ({o_inst, o_pc, o_pc_4, o_fault_misaligned, o_fault_access} !== e_head) begin
                    n_fail++;
                    $display("FAIL rand_data cyc=%0d got pc=%h inst=%h fm=%b fa=%b exp pc=%h inst=%h fm=%b fa=%b",
                             c, o_pc, o_inst, o_fault_misaligned, o_fault_access,
                             e_head.pc, e_head.inst, e_head.fm, e_head.fa);
                end
            end
            advance();
            if (rst || fl) f_pc = 32'($urandom_range(0, 4095)) << 2;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
        i_pc = '0; i_pc_4 = 32'd4; i_fault_misaligned = 1'b0; i_fault_access = 1'b0;
        i_imem_rdata = '0;
        m_busy = 1'b0; m_slot = '0; m_slot_flt = 1'b0; f_pc = '0;
        cur_rst = 1'b1; cur_flush = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_fault();
        test_flush();
        test_reset_mid();
        test_full_pushpop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
